axi4_lite_wr_master: RTL and testbench
======================================

Name: axi4_lite_wr_master

Overview:
Parametrised single-outstanding AXI4-Lite write master. It takes one write request (address, data, byte strobes) from user logic and issues the AW and W channels concurrently, each with its own independent handshake. It returns the slave's BRESP to the user on a response handshake and provides a watchdog timeout. It sits between user control logic and any AXI4-Lite slave (register banks, IP config ports).

Parameters:
ADDR_W, 32, address width (1..64)
DATA_W, 32, data width; legal values 32 or 64; STRB_W = DATA_W/8 is derived
TIMEOUT_CYCLES, 1024, watchdog limit in cycles from request accept to B handshake; 0 disables the watchdog

Ports:
clk  in  1  sole clock, rising edge
srst  in  1  synchronous active-high reset
wr_addr  in  ADDR_W  request address
wr_data  in  DATA_W  request data
wr_strb  in  STRB_W  request byte strobes
wr_valid  in  1  request valid
wr_ready  out  1  request accepted when wr_valid & wr_ready
wr_resp  out  2  BRESP of completed write, or 2'b10 on timeout
wr_resp_timeout  out  1  response was generated by the watchdog
wr_resp_valid  out  1  response valid
wr_resp_ready  in  1  user accepts response
m_axi_awaddr  out  ADDR_W  AW address
m_axi_awprot  out  3  fixed 3'b000
m_axi_awvalid  out  1  AW valid
m_axi_awready  in  1  AW ready
m_axi_wdata  out  DATA_W  W data
m_axi_wstrb  out  STRB_W  W strobes
m_axi_wvalid  out  1  W valid
m_axi_wready  in  1  W ready
m_axi_bresp  in  2  B response
m_axi_bvalid  in  1  B valid
m_axi_bready  out  1  B ready

Behaviour:
- Reset (srst high at a clk edge): state IDLE. wr_ready=1 in IDLE. All other outputs 0: awvalid, wvalid, bready, wr_resp_valid, wr_resp, wr_resp_timeout, awaddr, wdata, wstrb. Counter cleared. Reset mid-transaction abandons it without a response.
- All outputs are registered or decoded from the state register; there is no combinational path from any input to any output.
- States: IDLE, ISSUE, WAIT_B, RESP.
- IDLE: wr_ready=1. On wr_valid, capture addr/data/strb into holding registers and go to ISSUE. The user may change its inputs after accept.
- ISSUE: entered with awvalid=1 and wvalid=1 on the cycle after accept (latency 1).
  - Track aw_done and w_done flags. Drop awvalid on the cycle after its awready handshake, and wvalid on the cycle after its wready handshake. Channels complete in any order or in the same cycle.
  - While a valid is asserted, its payload is stable. When the valid is deasserted, the payload buses are 0.
  - When both channels are done (including same-cycle completion), go to WAIT_B.
- WAIT_B: bready=1. On bvalid, register bresp into wr_resp, set wr_resp_timeout=0, and go to RESP. bready drops on the next cycle. bvalid asserted earlier than WAIT_B is held by the slave per AXI and is not consumed.
- RESP: wr_resp_valid=1, held stable until wr_resp_ready, then go to IDLE (wr_ready=1 the next cycle). No back-to-back bypass; minimum request-to-request period is 4 cycles with a zero-wait slave.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter clears on accept and increments each cycle in ISSUE or WAIT_B.
  - When count==TIMEOUT_CYCLES-1 and the B handshake has not occurred that cycle, force state RESP with wr_resp=2'b10 and wr_resp_timeout=1, and deassert awvalid, wvalid and bready.
  - A B handshake in the same cycle as expiry wins: normal response with timeout=0.
  - After a timeout the slave is treated as broken; any recovery is by srst.
- Counter width is clog2(TIMEOUT_CYCLES+1) and it saturates; no wrap-around.
- wr_resp holds its last value while not valid. It is not cleared except by reset.

Test Plan:
- Zero-wait slave, addr=0x0000_0010, data=0xDEAD_BEEF, strb=4'hF: awvalid/wvalid high on cycle 1 with the captured values, bready on cycle 2, bvalid on cycle 2 gives wr_resp_valid on cycle 3 with resp=00 and timeout=0; wr_ready returns after resp_ready.
- awready delayed 3 cycles, wready immediate: wvalid drops after 1 cycle, awvalid stays high 4 cycles, bready asserts only after both are done; the same holds with the delays swapped.
- Slave returns bresp=2'b11 with wr_resp_ready held low 5 cycles: wr_resp=11 stays valid and stable for 5 cycles, and no new request is accepted until resp_ready.
- DATA_W=64, strb=8'h0F, data=0x1122334455667788: m_axi_wstrb=0x0F and wdata matches exactly. User inputs changed on the cycle after accept leave the AXI buses unchanged.
- TIMEOUT_CYCLES=8, slave never asserts awready: awvalid falls after 8 cycles, then wr_resp=10 with timeout=1; a second variant with bvalid in the expiry cycle gives timeout=0.
- srst asserted while in WAIT_B: on the next cycle wr_ready=1, all AXI valids and bready are 0, and no response is produced.

Source files
------------

// File: rtl/axi4_lite_wr_master.sv
// Single-outstanding AXI4-Lite write master: AW and W are issued together and
// complete independently; BRESP (or a watchdog timeout) is returned to the user.
module axi4_lite_wr_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [1:0]            wr_resp,
  output logic                  wr_resp_timeout,
  output logic                  wr_resp_valid,
  input  logic                  wr_resp_ready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam bit WD_EN  = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W  = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_B, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [1:0]          resp_q, resp_d;
  logic                tmo_q, tmo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                active, b_hs, expire;

  assign active = (state_q == S_ISSUE) || (state_q == S_WAIT_B);
  assign b_hs   = (state_q == S_WAIT_B) && m_axi_bvalid;
  // A B handshake in the expiry cycle takes precedence over the watchdog.
  assign expire = WD_EN && active && (cnt_q == CNT_LIMIT) && !b_hs;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      resp_q    <= 2'b00;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      resp_q    <= resp_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    resp_d    = resp_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (wr_valid) begin
          state_d   = S_ISSUE;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          addr_d    = wr_addr;
          data_d    = wr_data;
          strb_d    = wr_strb;
          cnt_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        else awvalid_d = awvalid_q;
        if (wvalid_q && m_axi_wready) wvalid_d = 1'b0;
        else wvalid_d = wvalid_q;
        if (!awvalid_d && !wvalid_d) state_d = S_WAIT_B;
        else state_d = S_ISSUE;
      end
      S_WAIT_B: begin
        if (m_axi_bvalid) begin
          state_d = S_RESP;
          resp_d  = m_axi_bresp;
          tmo_d   = 1'b0;
        end else begin
          state_d = S_WAIT_B;
        end
      end
      S_RESP: begin
        if (wr_resp_ready) state_d = S_IDLE;
        else state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
    // Watchdog: saturating count, forced timeout response on expiry.
    if (active) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      else cnt_d = cnt_q;
      if (expire) begin
        state_d   = S_RESP;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        resp_d    = 2'b10;
        tmo_d     = 1'b1;
      end else begin
        tmo_d = tmo_d;
      end
    end else begin
      cnt_d = cnt_d;
    end
  end

  always_comb begin
    wr_ready        = (state_q == S_IDLE);
    wr_resp_valid   = (state_q == S_RESP);
    m_axi_bready    = (state_q == S_WAIT_B);
    wr_resp         = resp_q;
    wr_resp_timeout = tmo_q;
    m_axi_awprot    = 3'b000;
    m_axi_awvalid   = awvalid_q;
    m_axi_wvalid    = wvalid_q;
    m_axi_awaddr    = awvalid_q ? addr_q : '0;
    m_axi_wdata     = wvalid_q ? data_q : '0;
    m_axi_wstrb     = wvalid_q ? strb_q : '0;
  end

endmodule

// File: tb/tb_axi4_lite_wr_master.sv
// Randomised self-checking bench for axi4_lite_wr_master (64-bit data, 8-cycle
// watchdog) against a cycle-count reference model of a single write transaction.
module tb_axi4_lite_wr_master;

  localparam int T = 8;

  typedef struct packed {
    int         aw_cyc;
    int         w_cyc;
    int         bready_first;
    int         resp_first;
    int         resp_cyc;
    logic [1:0] resp;
    logic       tmo;
    logic       rdy_after;
    logic       rv_after;
  } txn_t;

  logic        clk;
  logic        srst;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [1:0]  wr_resp;
  logic        wr_resp_timeout, wr_resp_valid, wr_resp_ready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid, m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;

  int n_checks = 0;
  int n_fail   = 0;

  axi4_lite_wr_master #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .srst(srst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_resp(wr_resp), .wr_resp_timeout(wr_resp_timeout),
    .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected transaction shape: cycle 1 is the first cycle after accept.
  // AW/W finish at cycle h, B handshake at cycle bc; watchdog expires at cycle T.
  function automatic txn_t model(input int da, input int dw, input int db,
                                 input int rr, input logic [1:0] br);
    txn_t m;
    int h, bc;
    h  = 1 + ((da > dw) ? da : dw);
    bc = h + 1 + db;
    m.aw_cyc       = (da + 1 < T) ? da + 1 : T;
    m.w_cyc        = (dw + 1 < T) ? dw + 1 : T;
    m.bready_first = (h + 1 <= T) ? h + 1 : 0;
    if (bc <= T) begin
      m.resp_first = bc + 1;
      m.resp       = br;
      m.tmo        = 1'b0;
    end else begin
      m.resp_first = T + 1;
      m.resp       = 2'b10;
      m.tmo        = 1'b1;
    end
    m.resp_cyc  = rr + 1;
    m.rdy_after = 1'b1;
    m.rv_after  = 1'b0;
    return m;
  endfunction

  task automatic do_reset();
    srst = 1'b1;
    wr_valid = 1'b0; wr_resp_ready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
  endtask

  // Drives one request plus a slave with the given wait states and records what
  // the DUT did; bad flags payload instability, nonzero idle buses or early wr_ready.
  task automatic run_txn(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                         input int da, input int dw, input int db, input int rr,
                         input logic [1:0] br, output txn_t o, output logic bad,
                         output logic [31:0] a1, output logic [63:0] d1, output logic [7:0] s1);
    int an, wn, bn, rn;
    logic aws, ws, bs, done;
    o = '0; bad = 1'b0; a1 = '0; d1 = '0; s1 = '0;
    an = 0; wn = 0; bn = 0; rn = 0;
    aws = 1'b0; ws = 1'b0; bs = 1'b0; done = 1'b0;
    wr_addr = a; wr_data = d; wr_strb = s; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_addr = $urandom; wr_data = {$urandom, $urandom}; wr_strb = 8'($urandom);
    for (int k = 1; k <= 60 && !done; k++) begin
      if (m_axi_awvalid) begin
        o.aw_cyc++;
        if (k == 1) a1 = m_axi_awaddr;
        if (m_axi_awaddr !== a) bad = 1'b1;
      end else if (m_axi_awaddr !== 32'h0) bad = 1'b1;
      if (m_axi_wvalid) begin
        o.w_cyc++;
        if (k == 1) begin d1 = m_axi_wdata; s1 = m_axi_wstrb; end
        if (m_axi_wdata !== d || m_axi_wstrb !== s) bad = 1'b1;
      end else if (m_axi_wdata !== 64'h0 || m_axi_wstrb !== 8'h0) bad = 1'b1;
      if (m_axi_awprot !== 3'b000 || wr_ready !== 1'b0) bad = 1'b1;
      if (m_axi_bready && o.bready_first == 0) o.bready_first = k;
      m_axi_bvalid = 1'b0;
      if (aws && ws && !bs) begin
        m_axi_bvalid = (bn >= db);
        m_axi_bresp = br;
        bn++;
        if (m_axi_bvalid && m_axi_bready) bs = 1'b1;
      end
      m_axi_awready = 1'b0;
      if (m_axi_awvalid && !aws) begin
        m_axi_awready = (an == da);
        an++;
        if (m_axi_awready) aws = 1'b1;
      end
      m_axi_wready = 1'b0;
      if (m_axi_wvalid && !ws) begin
        m_axi_wready = (wn == dw);
        wn++;
        if (m_axi_wready) ws = 1'b1;
      end
      wr_resp_ready = 1'b0;
      if (wr_resp_valid) begin
        if (o.resp_cyc == 0) begin
          o.resp_first = k; o.resp = wr_resp; o.tmo = wr_resp_timeout;
        end else if (wr_resp !== o.resp || wr_resp_timeout !== o.tmo) bad = 1'b1;
        o.resp_cyc++;
        wr_resp_ready = (rn >= rr);
        rn++;
        if (wr_resp_ready) done = 1'b1;
      end
      @(negedge clk);
    end
    wr_resp_ready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    o.rdy_after = wr_ready;
    o.rv_after  = wr_resp_valid;
  endtask

  task automatic test_reset();
    logic [114:0] got, exp;
    srst = 1'b1;
    repeat (2) @(negedge clk);
    got = {wr_ready, wr_resp_valid, wr_resp, wr_resp_timeout, m_axi_awvalid, m_axi_wvalid,
           m_axi_bready, m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_awprot};
    exp = {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 3'b000};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_state: got %h want %h", got, exp); end
    srst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    txn_t o, e; logic bad; logic [31:0] a1; logic [63:0] d1; logic [7:0] s1;
    run_txn(32'h0000_0010, 64'hDEAD_BEEF, 8'h0F, 0, 0, 0, 0, 2'b00, o, bad, a1, d1, s1);
    e = model(0, 0, 0, 0, 2'b00);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL zero_wait_timing: got %p want %p", o, e); end
    n_checks++;
    if ({a1, d1, s1} !== {32'h10, 64'hDEAD_BEEF, 8'h0F}) begin
      n_fail++; $display("FAIL zero_wait_payload: got %h %h %h want 10 deadbeef 0f", a1, d1, s1);
    end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL zero_wait_protocol: got %b want 0", bad); end
  endtask

  task automatic test_channel_delays();
    txn_t o, e; logic bad; logic [31:0] a1; logic [63:0] d1; logic [7:0] s1;
    for (int i = 0; i < 2; i++) begin
      run_txn(32'h100 + 32'(i), 64'h55AA_0000 + 64'(i), 8'hFF, (i == 0) ? 3 : 0, (i == 0) ? 0 : 3,
              0, 0, 2'b00, o, bad, a1, d1, s1);
      e = model((i == 0) ? 3 : 0, (i == 0) ? 0 : 3, 0, 0, 2'b00);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL delay_timing[%0d]: got %p want %p", i, o, e); end
      n_checks++;
      if (bad !== 1'b0) begin n_fail++; $display("FAIL delay_protocol[%0d]: got %b want 0", i, bad); end
    end
  endtask

  task automatic test_slave_error_hold();
    txn_t o, e; logic bad; logic [31:0] a1; logic [63:0] d1; logic [7:0] s1;
    run_txn(32'h200, 64'h1234, 8'h03, 0, 0, 1, 5, 2'b11, o, bad, a1, d1, s1);
    e = model(0, 0, 1, 5, 2'b11);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL error_hold_timing: got %p want %p", o, e); end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL error_hold_stable: got %b want 0", bad); end
  endtask

  task automatic test_wide_data();
    txn_t o, e; logic bad; logic [31:0] a1; logic [63:0] d1; logic [7:0] s1;
    run_txn(32'hA000_0008, 64'h1122_3344_5566_7788, 8'h0F, 1, 2, 0, 1, 2'b01, o, bad, a1, d1, s1);
    e = model(1, 2, 0, 1, 2'b01);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL wide_timing: got %p want %p", o, e); end
    n_checks++;
    if ({d1, s1} !== {64'h1122_3344_5566_7788, 8'h0F}) begin
      n_fail++; $display("FAIL wide_payload: got %h %h want 1122334455667788 0f", d1, s1);
    end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL wide_bus_stable: got %b want 0", bad); end
  endtask

  task automatic test_timeout();
    txn_t o, e; logic bad; logic [31:0] a1; logic [63:0] d1; logic [7:0] s1;
    run_txn(32'h300, 64'h77, 8'h01, 1000, 0, 0, 0, 2'b00, o, bad, a1, d1, s1);
    e = model(1000, 0, 0, 0, 2'b00);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL timeout_expiry: got %p want %p", o, e); end
    do_reset();
    run_txn(32'h304, 64'h88, 8'h02, 0, 0, 6, 0, 2'b01, o, bad, a1, d1, s1);
    e = model(0, 0, 6, 0, 2'b01);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL timeout_b_wins: got %p want %p", o, e); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic seen;
    wr_addr = 32'h400; wr_data = 64'h99; wr_strb = 8'hFF; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_axi_bready !== 1'b1) begin n_fail++; $display("FAIL mid_wait_b: got bready %b want 1", m_axi_bready); end
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    n_checks++;
    if ({wr_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, wr_resp_valid} !== 5'b10000) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b want 10000",
               {wr_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, wr_resp_valid});
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (wr_resp_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_resp: got %b want 0", seen); end
  endtask

  task automatic test_random();
    txn_t o, e; logic bad; logic [31:0] a1; logic [63:0] d1; logic [7:0] s1;
    int da, dw, db, rr; logic [1:0] br; logic [31:0] a; logic [63:0] d; logic [7:0] s;
    for (int i = 0; i < 16; i++) begin
      da = $urandom_range(0, 4); dw = $urandom_range(0, 4);
      db = $urandom_range(0, 3); rr = $urandom_range(0, 3);
      br = 2'($urandom); a = $urandom; d = {$urandom, $urandom}; s = 8'($urandom);
      run_txn(a, d, s, da, dw, db, rr, br, o, bad, a1, d1, s1);
      e = model(da, dw, db, rr, br);
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL random_txn[%0d] da=%0d dw=%0d db=%0d: got %p want %p", i, da, dw, db, o, e);
      end
      n_checks++;
      if (bad !== 1'b0) begin n_fail++; $display("FAIL random_protocol[%0d]: got %b want 0", i, bad); end
      if (e.tmo) do_reset();
    end
  endtask

  initial begin
    srst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; wr_resp_ready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    test_reset();
    test_zero_wait();
    test_channel_delays();
    test_slave_error_hold();
    test_wide_data();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
